// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle for fetch_stage
//
// Ports (signals):
//   imem_en     request strobe, one cycle per request (master drives)
//   imem_addr   request address (master drives)
//   imem_rdata  returned instruction word (slave drives)
//   imem_valid  one-cycle response strobe (slave drives)
// Modports: master (fetch side), slave (memory side).
interface fetch_stage_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with one-entry buffer and IF/ID register
//
// Owns the fetch PC, issues one outstanding request at a time to instruction
// memory, buffers the returned word in a single-entry ibuf, and drives the
// IF/ID pipeline register. Redirects from decode squash any in-flight fetch.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-PC detection,
// adds the adelD output).
//
// Ports:
//   clka                 core clock, rising edge
//   rst                  synchronous active-high reset
//   stallF / stallD      hazard-unit stalls (issue block / IF/ID hold)
//   flushD               IF/ID loads a bubble; wins over stallD
//   pcsrcD / pcbranchD   taken branch and its target
//   jumpD / pcjumpD      jump and its target; wins over pcsrcD
//   imem                 instruction memory bus (fetch_stage_if.master)
//   instrD, pcD, pcplus4D, validD   IF/ID register contents
//   fetch_busy           a request is outstanding (WAIT or DROP)
//   adelD                address-error flag for IF/ID (FETCH_ALIGN_CHECK_EN only)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 stallF,
  input  logic                 stallD,
  input  logic                 flushD,
  input  logic                 pcsrcD,
  input  logic [31:0]          pcbranchD,
  input  logic                 jumpD,
  input  logic [31:0]          pcjumpD,
  fetch_stage_if.master        imem,
  output logic [31:0]          instrD,
  output logic [31:0]          pcD,
  output logic [31:0]          pcplus4D,
  output logic                 validD,
  output logic                 fetch_busy
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                 adelD
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_f;
  logic [31:0] pc_f_nxt;

  logic        ibuf_valid;
  logic        ibuf_valid_nxt;
  logic [31:0] ibuf_pc;
  logic [31:0] ibuf_pc_nxt;
  logic [31:0] ibuf_instr;
  logic [31:0] ibuf_instr_nxt;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        drain;
  logic        ibuf_space;
  logic        can_issue;
  logic        issue;
  logic        req_en;

  assign redirect        = jumpD | pcsrcD;
  assign redirect_target = jumpD ? pcjumpD : pcbranchD;

  // The buffered word leaves ibuf whenever IF/ID is not held. Under flushD
  // with stallD low it still leaves (and is lost to the bubble).
  assign drain      = ibuf_valid & ~stallD;
  assign ibuf_space = ~ibuf_valid | drain;
  assign can_issue  = (state == IDLE) & ~stallF & ~redirect & ibuf_space;

`ifdef FETCH_ALIGN_CHECK_EN
  logic ibuf_adel;
  logic ibuf_adel_nxt;
  logic misaligned;
  logic adel_load;

  assign misaligned = (pc_f[1:0] != 2'b00);
  assign issue      = can_issue & ~misaligned;
  // A misaligned PC never reaches memory; the error is handed to decode
  // through ibuf and the PC parks here until decode redirects.
  assign adel_load  = can_issue & misaligned;
`else
  assign issue = can_issue;
`endif

  always_comb begin
    state_nxt      = state;
    pc_f_nxt       = pc_f;
    ibuf_valid_nxt = ibuf_valid;
    ibuf_pc_nxt    = ibuf_pc;
    ibuf_instr_nxt = ibuf_instr;
    req_en         = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    ibuf_adel_nxt  = ibuf_adel;
`endif

    if (drain) begin
      ibuf_valid_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (issue) begin
          req_en    = 1'b1;
          state_nxt = WAIT;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        if (adel_load) begin
          ibuf_valid_nxt = 1'b1;
          ibuf_pc_nxt    = pc_f;
          ibuf_instr_nxt = NOP_INSTR;
          ibuf_adel_nxt  = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (imem.imem_valid) begin
          state_nxt = IDLE;
          // A response coinciding with a redirect belongs to the old path.
          if (!redirect) begin
            ibuf_valid_nxt = 1'b1;
            ibuf_pc_nxt    = pc_f;
            ibuf_instr_nxt = imem.imem_rdata;
            pc_f_nxt       = pc_f + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
            ibuf_adel_nxt  = 1'b0;
`endif
          end
        end else if (redirect) begin
          // Response still owed by memory; swallow it when it shows up.
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem.imem_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Redirect overrides the PC and squashes ibuf whatever the state or stalls.
    if (redirect) begin
      pc_f_nxt       = redirect_target;
      ibuf_valid_nxt = 1'b0;
    end
  end

  assign imem.imem_en   = req_en & ~rst;
  assign imem.imem_addr = pc_f;

  always_ff @(posedge clka) begin
    if (rst) begin
      state      <= IDLE;
      pc_f       <= RESET_PC;
      ibuf_valid <= 1'b0;
      ibuf_pc    <= 32'd0;
      ibuf_instr <= NOP_INSTR;
      fetch_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_f       <= pc_f_nxt;
      ibuf_valid <= ibuf_valid_nxt;
      ibuf_pc    <= ibuf_pc_nxt;
      ibuf_instr <= ibuf_instr_nxt;
      fetch_busy <= (state_nxt != IDLE);
    end
  end

  // IF/ID register: flush, then stall, then load from ibuf, else bubble.
  always_ff @(posedge clka) begin
    if (rst || flushD) begin
      instrD   <= NOP_INSTR;
      pcD      <= 32'd0;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end else if (stallD) begin
      instrD   <= instrD;
      pcD      <= pcD;
      pcplus4D <= pcplus4D;
      validD   <= validD;
    end else if (ibuf_valid) begin
      instrD   <= ibuf_instr;
      pcD      <= ibuf_pc;
      pcplus4D <= ibuf_pc + 32'd4;
      validD   <= 1'b1;
    end else begin
      instrD   <= NOP_INSTR;
      pcD      <= 32'd0;
      pcplus4D <= 32'd0;
      validD   <= 1'b0;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clka) begin
    if (rst) begin
      ibuf_adel <= 1'b0;
      adelD     <= 1'b0;
    end else begin
      ibuf_adel <= ibuf_adel_nxt;
      if (flushD) begin
        adelD <= 1'b0;
      end else if (stallD) begin
        adelD <= adelD;
      end else if (ibuf_valid) begin
        adelD <= ibuf_adel;
      end else begin
        adelD <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

  logic        clka = 1'b0;
  logic        rst;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        jumpD;
  logic [31:0] pcjumpD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic        fetch_busy;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        adelD;
`endif

  always #5 clka = ~clka;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clka      (clka),
    .rst       (rst),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .pcsrcD    (pcsrcD),
    .pcbranchD (pcbranchD),
    .jumpD     (jumpD),
    .pcjumpD   (pcjumpD),
    .imem      (imem_bus),
    .instrD    (instrD),
    .pcD       (pcD),
    .pcplus4D  (pcplus4D),
    .validD    (validD),
    .fetch_busy(fetch_busy)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .adelD     (adelD)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // stimulus applied at the next tick
  logic        nxt_rst     = 1'b1;
  logic        nxt_stallF  = 1'b0;
  logic        nxt_stallD  = 1'b0;
  logic        nxt_flushD  = 1'b0;
  logic        nxt_jumpD   = 1'b0;
  logic        nxt_pcsrcD  = 1'b0;
  logic [31:0] nxt_pcjumpD = 32'd0;
  logic [31:0] nxt_pcbranchD = 32'd0;

  // memory model: returns addr ^ FFFF_FFFF after mem_k cycles
  int          mem_k      = 1;
  bit          mem_busy   = 1'b0;
  int          mem_cnt    = 0;
  logic [31:0] mem_addr   = 32'd0;
  bit          mem_squash = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  bit          sb_en     = 1'b1;
  bit          prev_load = 1'b0;
  int          cyc       = 0;
  bit          resp_now  = 1'b0;
  bit          req_now   = 1'b0;
  logic [31:0] resp_data = 32'd0;
  int          en_seen   = 0;
  int          req_cyc[$];
  logic [31:0] req_addr[$];

  task automatic tick();
    exp_t e;
    bit   redir;
    @(negedge clka);
    // IF/ID just loaded from ibuf at the last edge: compare with scoreboard
    if (sb_en && prev_load && validD === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("sb_stray_instr", {31'd0, validD}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_instrD", instrD, e.instr);
        check_eq("sb_pcD", pcD, e.pc);
        check_eq("sb_pcplus4D", pcplus4D, e.pc + 32'd4);
      end
    end
    prev_load = !nxt_rst && !nxt_stallD && !nxt_flushD;

    rst       = nxt_rst;
    stallF    = nxt_stallF;
    stallD    = nxt_stallD;
    flushD    = nxt_flushD;
    jumpD     = nxt_jumpD;
    pcsrcD    = nxt_pcsrcD;
    pcjumpD   = nxt_pcjumpD;
    pcbranchD = nxt_pcbranchD;

    redir    = nxt_jumpD | nxt_pcsrcD;
    resp_now = 1'b0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = $urandom;
    if (nxt_rst) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt == 1) begin
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = ~mem_addr;
        mem_busy = 1'b0;
        if (!mem_squash && !redir) begin
          sb.push_back('{pc: mem_addr, instr: ~mem_addr});
          resp_now  = 1'b1;
          resp_data = ~mem_addr;
        end
      end else begin
        mem_cnt--;
        if (redir) mem_squash = 1'b1;
      end
    end
    cyc++;
    #1;
    req_now = 1'b0;
    if (imem_bus.imem_en === 1'b1) begin
      if (nxt_rst) check_eq("en_in_reset", {31'd0, imem_bus.imem_en}, 32'd0);
      check_eq("one_outstanding", {31'd0, mem_busy}, 32'd0);
      mem_busy   = 1'b1;
      mem_cnt    = mem_k;
      mem_addr   = imem_bus.imem_addr;
      mem_squash = 1'b0;
      en_seen++;
      req_now = 1'b1;
      req_cyc.push_back(cyc);
      req_addr.push_back(imem_bus.imem_addr);
    end
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!resp_now && n < 20);
    check_eq(tag, {31'd0, resp_now}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!req_now && n < 20);
    check_eq(tag, {31'd0, req_now}, 32'd1);
  endtask

  logic [31:0] snap;
  logic [31:0] buffered;
  int          jcyc;
  bit          found;

  initial begin
    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
    pcsrcD = 1'b0; jumpD = 1'b0; pcbranchD = 32'd0; pcjumpD = 32'd0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;

    // reset
    repeat (3) tick();
    check_eq("rst_imem_en", {31'd0, imem_bus.imem_en}, 32'd0);
    check_eq("rst_instrD", instrD, 32'h0000_0000);
    check_eq("rst_pcD", pcD, 32'd0);
    check_eq("rst_pcplus4D", pcplus4D, 32'd0);
    check_eq("rst_validD", {31'd0, validD}, 32'd0);
    check_eq("rst_fetch_busy", {31'd0, fetch_busy}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_adelD", {31'd0, adelD}, 32'd0);
`endif

    // release, k=1
    nxt_rst = 1'b0;
    cyc = -1;
    req_cyc.delete();
    req_addr.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cyc == 2) check_eq("first_validD_c2", {31'd0, validD}, 32'd0);
      if (cyc == 3) begin
        check_eq("first_instrD_c3", instrD, 32'h403F_FFFF);
        check_eq("first_pcD_c3", pcD, 32'hBFC0_0000);
        check_eq("first_validD_c3", {31'd0, validD}, 32'd1);
      end
    end
    check_eq("req_count", {31'd0, req_cyc.size() >= 3}, 32'd1);
    if (req_cyc.size() >= 3) begin
      check_eq("req0_cyc", req_cyc[0], 32'd0);
      check_eq("req0_addr", req_addr[0], 32'hBFC0_0000);
      check_eq("req1_cyc", req_cyc[1], 32'd2);
      check_eq("req1_addr", req_addr[1], 32'hBFC0_0004);
      check_eq("req2_cyc", req_cyc[2], 32'd4);
      check_eq("req2_addr", req_addr[2], 32'hBFC0_0008);
    end

    // stallD for 3 cycles with ibuf full
    wait_resp("stall_resp_seen");
    buffered = resp_data;
    nxt_stallD = 1'b1;
    en_seen = 0;
    tick();
    snap = instrD;
    tick();
    check_eq("stall_hold_1", instrD, snap);
    tick();
    check_eq("stall_hold_2", instrD, snap);
    check_eq("stall_no_en", en_seen, 32'd0);
    nxt_stallD = 1'b0;
    tick();
    check_eq("stall_hold_3", instrD, snap);
    check_eq("stall_release_en", {31'd0, imem_bus.imem_en}, 32'd1);
    tick();
    check_eq("stall_release_instrD", instrD, buffered);
    check_eq("stall_release_validD", {31'd0, validD}, 32'd1);

    // flushD + stallD with ibuf valid
    wait_resp("flush_resp_seen");
    buffered = resp_data;
    nxt_stallD = 1'b1;
    nxt_flushD = 1'b1;
    tick();
    nxt_stallD = 1'b0;
    nxt_flushD = 1'b0;
    tick();
    check_eq("flush_instrD", instrD, 32'h0000_0000);
    check_eq("flush_validD", {31'd0, validD}, 32'd0);
    tick();
    check_eq("flush_ibuf_kept", instrD, buffered);
    check_eq("flush_ibuf_valid", {31'd0, validD}, 32'd1);

    // jump while WAIT, k=3
    mem_k = 3;
    wait_req("jump_req_seen");
    nxt_jumpD = 1'b1;
    nxt_pcjumpD = 32'h0000_0100;
    tick();
    jcyc = cyc;
    nxt_jumpD = 1'b0;
    tick();
    check_eq("drop_busy", {31'd0, fetch_busy}, 32'd1);
    check_eq("drop_no_en", {31'd0, imem_bus.imem_en}, 32'd0);
    wait_req("jump_target_req_seen");
    check_eq("jump_target_addr", imem_bus.imem_addr, 32'h0000_0100);
    check_eq("jump_target_cyc", cyc, jcyc + 3);

    // PC wrap at FFFF_FFFC
    wait_req("wrap_pre_req_seen");
    nxt_pcsrcD = 1'b1;
    nxt_pcbranchD = 32'hFFFF_FFFC;
    tick();
    nxt_pcsrcD = 1'b0;
    wait_req("wrap_req_seen");
    check_eq("wrap_req_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    wait_req("wrap_next_req_seen");
    check_eq("wrap_next_addr", imem_bus.imem_addr, 32'h0000_0000);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (validD === 1'b1 && pcD === 32'hFFFF_FFFC) found = 1'b1;
    end
    check_eq("wrap_ifid_seen", {31'd0, found}, 32'd1);
    if (found) check_eq("wrap_pcplus4D", pcplus4D, 32'h0000_0000);

    // stallF: outstanding request still completes and reaches IF/ID
    nxt_stallF = 1'b1;
    repeat (10) tick();
    check_eq("sb_drained", sb.size(), 32'd0);
    nxt_stallF = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
    wait_req("align_req_seen");
    nxt_jumpD = 1'b1;
    nxt_pcjumpD = 32'h0000_0102;
    tick();
    nxt_jumpD = 1'b0;
    sb_en = 1'b0;
    en_seen = 0;
    repeat (8) tick();
    check_eq("align_no_en", en_seen, 32'd0);
    check_eq("align_adelD", {31'd0, adelD}, 32'd1);
    check_eq("align_instrD", instrD, 32'h0000_0000);
    check_eq("align_pcD", pcD, 32'h0000_0102);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the five-stage pipelined MIPS core, directly upstream of `controller`. It owns the fetch PC, issues one-outstanding requests to instruction memory, buffers the returned word, and drives the IF/ID pipeline register whose `instrD` output feeds `controller.instr` and the decode datapath. It honours hazard-unit stall and flush requests and squashes in-flight fetches on branch or jump redirects from decode.

## Interface
- `RESET_PC`, 32'hBFC0_0000, fetch address after reset
- `NOP_INSTR`, 32'h0000_0000, word driven on `instrD` for bubbles

- `clka` in 1: core clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `stallF` in 1: hazard unit; blocks issue of new requests
- `stallD` in 1: hazard unit; IF/ID holds
- `flushD` in 1: hazard unit; IF/ID loads bubble; wins over `stallD`
- `pcsrcD` in 1: branch taken in decode
- `pcbranchD` in 32: branch target
- `jumpD` in 1: jump in decode; wins over `pcsrcD`
- `pcjumpD` in 32: jump target
- `imem_en` out 1: request strobe, one cycle per request
- `imem_addr` out 32: request address (= `pcF`)
- `imem_rdata` in 32: returned instruction
- `imem_valid` in 1: one-cycle response strobe, ≥1 cycle after `imem_en`
- `instrD` out 32: IF/ID instruction, to `controller`
- `pcD` out 32: IF/ID PC
- `pcplus4D` out 32: IF/ID PC+4
- `validD` out 1: IF/ID holds a real instruction
- `fetch_busy` out 1: request outstanding (states WAIT or DROP)

## Operation
- State machine: IDLE, WAIT, DROP.
- IDLE: issue (`imem_en`=1, `imem_addr`=`pcF`) when `!stallF`, no redirect this cycle, and ibuf empty or draining this cycle; then go to WAIT. `imem_valid` is ignored in IDLE.
- WAIT: on `imem_valid`, write ibuf ← {`pcF`, `imem_rdata`}, set `pcF` ← `pcF`+4 (32-bit, wraps modulo 2^32), and go to IDLE.
- DROP: on `imem_valid`, discard the data and go to IDLE. `pcF` is not advanced.
- Redirect (`jumpD` or `pcsrcD`):
  - `pcF` ← target (`pcjumpD` if `jumpD`, else `pcbranchD`) and ibuf is cleared, in any state.
  - If WAIT with no `imem_valid` this cycle: go to DROP.
  - If WAIT with `imem_valid` this cycle: the response is discarded; go to IDLE.
  - Applies regardless of `stallF`/`stallD`.
  - IF/ID is not cleared by a redirect; squashing D is done by the hazard unit via `flushD`.
- ibuf: one entry. It drains when `!stallD`.
- IF/ID update priority:
  1. `flushD`: bubble (`instrD`=`NOP_INSTR`, `validD`=0, `pcD`/`pcplus4D`=0).
  2. `stallD`: hold.
  3. ibuf valid: load {pc, pc+4, instr}, `validD`=1, ibuf cleared.
  4. Otherwise: bubble.
- Response and drain in the same cycle: the old ibuf entry moves to IF/ID and the new word enters ibuf.
- `stallF` never cancels an outstanding request. Its response is still captured into ibuf.

## Timing
- Reset values:
  - `pcF`=`RESET_PC`, state IDLE, ibuf empty.
  - `instrD`=`NOP_INSTR`, `pcD`=0, `pcplus4D`=0, `validD`=0.
  - `imem_en` forced 0 while `rst`=1; `fetch_busy`=0.
- Reset mid-request: return to IDLE. The instruction memory shares `rst`, so no stale response arrives.
- First request in the first cycle after `rst` deasserts (cycle 0). With k=1 memory latency, `instrD` is valid from cycle 3.
- Request at cycle t, `imem_valid` at t+k: ibuf valid at t+k+1, IF/ID valid at t+k+2 if `!stallD`. Next request issues at t+k+1.
- Throughput: one instruction per k+1 cycles when unstalled.
- `imem_en`/`imem_addr` are combinational from state and `pcF`. All other outputs are registered.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In IDLE, `pcF[1:0]`≠0 suppresses the request.
  - ibuf is loaded directly with {`pcF`, `NOP_INSTR`} plus an `adelF` flag.
  - The flag propagates to an extra output `adelD` (reset 0) alongside IF/ID.
  - `pcF` does not advance; it waits for a redirect.
- Not defined: no check; `imem_addr` carries `pcF` unmodified and the `adelD` port does not exist.

## Test plan
- Reset release, memory k=1 returning `imem_addr`^32'hFFFF_FFFF: `imem_addr` sequence BFC00000, BFC00004, BFC00008 on every second cycle; `instrD`=403FFFFF from cycle 3 with `pcD`=BFC00000.
- `stallD` high 3 cycles with ibuf full: IF/ID holds; no new `imem_en`; on release, the buffered word enters IF/ID next edge.
- `jumpD`=1, `pcjumpD`=0000_0100 while WAIT with k=3: state DROP, old response discarded, next `imem_addr`=00000100, no stale word reaches `instrD`.
- `flushD` and `stallD` both high with ibuf valid: `instrD`=`NOP_INSTR`, `validD`=0; ibuf retained.
- `pcF`=FFFF_FFFC: after response, `pcF`=0000_0000; `pcplus4D`=0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0000_0102: no `imem_en`; `adelD`=1, `instrD`=`NOP_INSTR`, `pcD`=00000102.
